// File: rtl/wb_regfile.sv
// rtl/wb_regfile.sv - pipeline register file with write-back result select and write-through bypass
//
// Purpose:
//   Register file for a five-stage pipeline. It holds 2**ADDR_W registers of
//   DATA_W bits and has one write port, fed from the MEM/WB stage. It has two
//   asynchronous read ports, used by the decode stage. Register 0 is hardwired
//   to zero. A write in the same cycle as a read of the same index is forwarded
//   to the read port, so decode sees write-before-read behaviour.
//
// Ports:
//   CLK        in   1       clock; all state changes on the rising edge
//   RST        in   1       asynchronous active-high reset; clears every register
//   RegWriteW  in   1       write-back enable
//   MemToRegW  in   1       result select: 1 = ReadDataW, 0 = ALUOutW
//   ALUOutW    in   DATA_W  ALU result
//   ReadDataW  in   DATA_W  load data
//   WriteRegW  in   ADDR_W  destination register index
//   A1, A2     in   ADDR_W  read indices
//   RD1, RD2   out  DATA_W  read data (zero latency, bypassed)
//   ResultW    out  DATA_W  selected write-back value (also used for forwarding)

module wb_regfile #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              RegWriteW,
  input  logic              MemToRegW,
  input  logic [DATA_W-1:0] ALUOutW,
  input  logic [DATA_W-1:0] ReadDataW,
  input  logic [ADDR_W-1:0] WriteRegW,
  input  logic [ADDR_W-1:0] A1,
  input  logic [ADDR_W-1:0] A2,
  output logic [DATA_W-1:0] RD1,
  output logic [DATA_W-1:0] RD2,
  output logic [DATA_W-1:0] ResultW
);

  localparam int NREGS = 2 ** ADDR_W;

  logic [DATA_W-1:0] regs [NREGS];
  logic              wr_en;
  logic              byp1;
  logic              byp2;

  assign ResultW = MemToRegW ? ReadDataW : ALUOutW;

  // Index 0 is never written, so it keeps its reset value of zero.
  assign wr_en = RegWriteW && (WriteRegW != '0);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < NREGS; i++) begin
        regs[i] <= '0;
      end
    end else if (wr_en) begin
      regs[WriteRegW] <= ResultW;
    end
  end

  // Forward the value being written this cycle, so that a read in the same
  // cycle sees the new data. Reset disables the bypass, so the read ports stay
  // at zero while RST is high.
  assign byp1 = wr_en && (WriteRegW == A1);
  assign byp2 = wr_en && (WriteRegW == A2);

  always_comb begin
    RD1 = '0;
    RD2 = '0;
    if (!RST) begin
      if (A1 != '0) begin
        RD1 = byp1 ? ResultW : regs[A1];
      end
      if (A2 != '0) begin
        RD2 = byp2 ? ResultW : regs[A2];
      end
    end
  end

endmodule
